// File: rtl/pulpemu_clk_div_pkg.sv
// Shared widths and per-channel state types for the multi-channel clock divider.
// cnt_t fixes the counter width, so the top's CNT_W must equal DIV_CNT_W.
package pulpemu_clk_div_pkg;

    localparam int DIV_NUM_CH = 4;
    localparam int DIV_CNT_W  = 16;

    function automatic int ch_idx_w(input int num_ch);
        return $clog2(num_ch) + 1;
    endfunction

    localparam int CH_IDX_W = ch_idx_w(DIV_NUM_CH);

    typedef logic [DIV_CNT_W-1:0] cnt_t;

    typedef struct packed {
        cnt_t cnt;
        cnt_t div;
        cnt_t pend_div;
        logic pending;
    } ch_state_t;

endpackage

// File: rtl/pulpemu_clk_div_ch.sv
// One divider channel: period counter, registered outputs and a pending divisor
// that is swapped in only at a period boundary (or at once when disabled / D=1).
module pulpemu_clk_div_ch
    import pulpemu_clk_div_pkg::*;
#(
    parameter cnt_t RESET_DIV = cnt_t'(256)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  cnt_t load_div_i,
    output logic div_clk_o,
    output logic tick_o,
    output logic busy_o
);

    ch_state_t st_q, st_d;
    logic      div_clk_q, div_clk_d;
    logic      tick_q, tick_d;
    logic      enabled, period_end, apply;

    always_comb begin
        st_d       = st_q;
        enabled    = (st_q.div != '0);
        period_end = enabled && (st_q.cnt == st_q.div - cnt_t'(1));
        apply      = st_q.pending && ((st_q.div <= cnt_t'(1)) || period_end);

        // D>>1 is zero for D=0 and D=1, so those channels never drive the clock high.
        tick_d    = enabled && (st_q.cnt == '0);
        div_clk_d = (st_q.cnt < (st_q.div >> 1));

        if (!enabled || period_end) begin
            st_d.cnt = '0;
        end else begin
            st_d.cnt = st_q.cnt + cnt_t'(1);
        end

        if (apply) begin
            st_d.div     = st_q.pend_div;
            st_d.cnt     = '0;
            st_d.pending = 1'b0;
        end

        if (load_i) begin
            st_d.pending  = 1'b1;
            st_d.pend_div = load_div_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            st_q      <= '{cnt: '0, div: RESET_DIV, pend_div: '0, pending: 1'b0};
            div_clk_q <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            st_q      <= st_d;
            div_clk_q <= div_clk_d;
            tick_q    <= tick_d;
        end
    end

    assign div_clk_o = div_clk_q;
    assign tick_o    = tick_q;
    assign busy_o    = st_q.pending;

endmodule

// File: rtl/pulpemu_clk_div_multi.sv
// Multi-channel programmable clock divider: config decode, ready mux and error
// flag around NUM_CH independent divider channels.
module pulpemu_clk_div_multi
    import pulpemu_clk_div_pkg::*;
#(
    parameter int                      NUM_CH      = DIV_NUM_CH,
    parameter int                      CNT_W       = DIV_CNT_W,
    parameter logic [NUM_CH*CNT_W-1:0] DEFAULT_DIV = {NUM_CH{CNT_W'(256)}}
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_valid_i,
    output logic                         cfg_ready_o,
    input  logic [ch_idx_w(NUM_CH)-1:0]  cfg_ch_i,
    input  logic [CNT_W-1:0]             cfg_div_i,
    output logic                         cfg_err_o,
    output logic [NUM_CH-1:0]            div_clk_o,
    output logic [NUM_CH-1:0]            tick_o,
    output logic [NUM_CH-1:0]            busy_o
);

    localparam int IDX_W = ch_idx_w(NUM_CH);

    logic [NUM_CH-1:0] load;
    logic [NUM_CH-1:0] busy;
    logic              in_range;
    logic              cfg_ready;
    logic              err_q, err_d;

    // Out-of-range requests are always accepted so they can be flagged and dropped.
    always_comb begin
        in_range  = (cfg_ch_i < IDX_W'(NUM_CH));
        cfg_ready = 1'b1;
        load      = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (cfg_ch_i == IDX_W'(c)) begin
                cfg_ready = ~busy[c];
                load[c]   = cfg_valid_i & ~busy[c];
            end
        end
        err_d = cfg_valid_i & ~in_range;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pulpemu_clk_div_ch #(
            .RESET_DIV (cnt_t'(DEFAULT_DIV[g*CNT_W +: CNT_W]))
        ) u_ch (
            .clk_i      (clk_i),
            .rst_i      (rst_i),
            .load_i     (load[g]),
            .load_div_i (cnt_t'(cfg_div_i)),
            .div_clk_o  (div_clk_o[g]),
            .tick_o     (tick_o[g]),
            .busy_o     (busy[g])
        );
    end

    assign cfg_ready_o = cfg_ready;
    assign cfg_err_o   = err_q;
    assign busy_o      = busy;

endmodule
